// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: pipeline control levels,
// LSU state encodings, exception bit indices and load/store op codes.
package mem_lsu_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_HOLD = 2'd2
    } lsu_state_e;

    localparam int unsigned EXC_LOAD_MISALIGN  = 4;
    localparam int unsigned EXC_LOAD_FAULT     = 5;
    localparam int unsigned EXC_STORE_MISALIGN = 6;
    localparam int unsigned EXC_STORE_FAULT    = 7;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } access_size_e;

    // Captured at issue so the bus side stays stable while the pipeline is stalled.
    typedef struct packed {
        logic [7:0]  op;
        logic [1:0]  lo;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_req_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic access_size_e access_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
            EXE_LW_OP, EXE_SW_OP:             return SZ_WORD;
            default:                          return SZ_NONE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (access_size(op))
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Little-endian byte-lane steering: store lane/sel generation (LOAD_DIR=0) or
// load lane extract with sign/zero extension (LOAD_DIR=1).
module lsu_lane_align
    import mem_lsu_pkg::*;
#(
    parameter bit LOAD_DIR = 1'b0
) (
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  sel_o,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = data_i >> {addr_lo_i, 3'b000};

    always_comb begin
        sel_o = 4'b0000;
        case (access_size(aluop_i))
            SZ_BYTE: sel_o = 4'b0001 << addr_lo_i;
            SZ_HALF: sel_o = 4'b0011 << addr_lo_i;
            SZ_WORD: sel_o = 4'b1111;
            default: sel_o = 4'b0000;
        endcase
    end

    always_comb begin
        data_o = 32'h0;
        if (LOAD_DIR) begin
            case (aluop_i)
                EXE_LB_OP:  data_o = {{24{shifted[7]}}, shifted[7:0]};
                EXE_LBU_OP: data_o = {24'h0, shifted[7:0]};
                EXE_LH_OP:  data_o = {{16{shifted[15]}}, shifted[15:0]};
                EXE_LHU_OP: data_o = {16'h0, shifted[15:0]};
                EXE_LW_OP:  data_o = data_i;
                default:    data_o = 32'h0;
            endcase
        end else begin
            // Replicate across lanes; the slave picks the lanes named by sel.
            case (access_size(aluop_i))
                SZ_BYTE: data_o = {4{data_i[7:0]}};
                SZ_HALF: data_o = {2{data_i[15:0]}};
                SZ_WORD: data_o = data_i;
                default: data_o = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one Wishbone-classic transfer per load/store, stall
// request while busy. Optional bus watchdog enabled by `define MEM_LSU_TIMEOUT_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] excepttype_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] excepttype_o,
    output logic        stallreq_o,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_adr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_dat_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack_i
);

    lsu_state_e  state_q;
    bus_req_t    req_q, req_d;
    logic [31:0] rd_buf_q;

    logic [3:0]  st_sel, ld_sel_unused;
    logic [31:0] st_dat, ld_dat;
    logic        mem_op, has_exc, misalign, issue;
    logic        in_busy, ack_now, timeout, bus_active;
    logic [31:0] local_exc;
    logic        unused_ok;

    assign mem_op   = is_load(aluop_i) || is_store(aluop_i);
    assign has_exc  = |excepttype_i;
    assign misalign = mem_op && !has_exc && misaligned(aluop_i, mem_addr_i[1:0]);
    assign issue    = (state_q == LSU_IDLE) && mem_op && !has_exc && !misalign && !flush;
    assign in_busy  = (state_q == LSU_BUSY);
    assign ack_now  = in_busy && dbus_ack_i && !flush;

    lsu_lane_align #(.LOAD_DIR(1'b0)) u_store_align (
        .aluop_i   (aluop_i),
        .addr_lo_i (mem_addr_i[1:0]),
        .data_i    (reg2_i),
        .sel_o     (st_sel),
        .data_o    (st_dat)
    );

    lsu_lane_align #(.LOAD_DIR(1'b1)) u_load_align (
        .aluop_i   (req_q.op),
        .addr_lo_i (req_q.lo),
        .data_i    (dbus_dat_i),
        .sel_o     (ld_sel_unused),
        .data_o    (ld_dat)
    );

    always_comb begin
        req_d = req_q;
        if (issue) begin
            req_d.op  = aluop_i;
            req_d.lo  = mem_addr_i[1:0];
            req_d.we  = is_store(aluop_i);
            req_d.adr = {mem_addr_i[31:2], 2'b00};
            req_d.sel = st_sel;
            req_d.dat = is_store(aluop_i) ? st_dat : 32'h0;
        end
    end

`ifdef MEM_LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;

    assign timeout = in_busy && !dbus_ack_i && !flush && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= 8'h0;
        end else if (issue) begin
            cnt_q <= 8'h0;
        end else if (in_busy) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Issue-cycle signals come straight from the EX/MEM inputs; later cycles replay the capture.
    assign bus_active = !rst && (issue || (in_busy && !dbus_ack_i && !flush && !timeout));
    assign stallreq_o = bus_active;
    assign dbus_cyc_o = bus_active;
    assign dbus_stb_o = bus_active;
    assign dbus_we_o  = bus_active ? req_d.we  : 1'b0;
    assign dbus_adr_o = bus_active ? req_d.adr : 32'h0;
    assign dbus_sel_o = bus_active ? req_d.sel : 4'h0;
    assign dbus_dat_o = bus_active ? req_d.dat : 32'h0;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= LSU_IDLE;
            req_q    <= '0;
            rd_buf_q <= 32'h0;
        end else begin
            req_q <= req_d;
            case (state_q)
                LSU_IDLE: begin
                    if (issue) state_q <= LSU_BUSY;
                end
                LSU_BUSY: begin
                    if (flush || timeout) begin
                        state_q <= LSU_IDLE;
                    end else if (dbus_ack_i) begin
                        if (is_load(req_q.op)) rd_buf_q <= ld_dat;
                        state_q <= (stall[4] == Stop) ? LSU_HOLD : LSU_IDLE;
                    end
                end
                LSU_HOLD: begin
                    if (flush || stall[4] == NoStop) state_q <= LSU_IDLE;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    always_comb begin
        local_exc = 32'h0;
        if (misalign) begin
            if (is_load(aluop_i)) local_exc[EXC_LOAD_MISALIGN]  = 1'b1;
            else                  local_exc[EXC_STORE_MISALIGN] = 1'b1;
        end
        if (timeout) begin
            if (is_load(req_q.op)) local_exc[EXC_LOAD_FAULT]  = 1'b1;
            else                   local_exc[EXC_STORE_FAULT] = 1'b1;
        end
    end

    always_comb begin
        wd_o         = 5'h0;
        wreg_o       = 1'b0;
        wdata_o      = 32'h0;
        excepttype_o = 32'h0;
        if (!rst) begin
            wd_o         = wd_i;
            wreg_o       = wreg_i && !misalign && !timeout;
            excepttype_o = excepttype_i | local_exc;
            wdata_o      = wdata_i;
            if (state_q == LSU_HOLD && is_load(req_q.op)) begin
                wdata_o = rd_buf_q;
            end else if (ack_now && is_load(req_q.op)) begin
                wdata_o = ld_dat;
            end
        end
    end

    assign unused_ok = ^{stall[5], stall[3:0], ld_sel_unused, TIMEOUT_CYCLES[0]};

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized bench for mem_lsu with a lane/extension reference model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk, rst, flush;
    logic [5:0]  stall;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o;
    logic [31:0] wdata_i, wdata_o, mem_addr_i, reg2_i, excepttype_i, excepttype_o;
    logic [7:0]  aluop_i;
    logic        stallreq_o, dbus_cyc_o, dbus_stb_o, dbus_we_o, dbus_ack_i;
    logic [31:0] dbus_adr_o, dbus_dat_o, dbus_dat_i;
    logic [3:0]  dbus_sel_o;

    int checks = 0;
    int errors = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .excepttype_i(excepttype_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .excepttype_o(excepttype_o),
        .stallreq_o(stallreq_o), .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o),
        .dbus_we_o(dbus_we_o), .dbus_adr_o(dbus_adr_o), .dbus_sel_o(dbus_sel_o),
        .dbus_dat_o(dbus_dat_o), .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian arithmetic.
    function automatic int ref_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            default:                          return 4;
        endcase
    endfunction

    function automatic bit ref_is_load(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
        int m;
        m = ((1 << ref_size(op)) - 1) << int'(addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_store(input logic [7:0] op, input logic [31:0] d);
        case (ref_size(op))
            1:       return (d % 256) * 32'h0101_0101;
            2:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] v;
        bit sgn;
        sgn = (op == EXE_LB_OP) || (op == EXE_LH_OP);
        v = w >> (8 * int'(addr % 4));
        if (ref_size(op) == 1) begin
            v = v % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (ref_size(op) == 2) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic drive_idle();
        aluop_i = EXE_NOP_OP; mem_addr_i = 32'h0; reg2_i = 32'h0; wdata_i = 32'h0;
        wreg_i = 1'b0; wd_i = 5'h0; excepttype_i = 32'h0; stall = 6'h0; flush = 1'b0;
        dbus_ack_i = 1'b0; dbus_dat_i = 32'h0;
    endtask

    // One full load/store: ack arrives `lat` cycles after issue, then `hold` cycles in HOLD.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] st,
                           input logic [31:0] rdat, input int lat, input int hold);
        logic [31:0] exp_w;
        int stalls;
        bit ld;
        ld = ref_is_load(op);
        stalls = 0;
        @(negedge clk);
        aluop_i = op; mem_addr_i = addr; reg2_i = st; wdata_i = addr ^ 32'h5A5A_0000;
        wreg_i = ld; wd_i = 5'($urandom_range(1, 31)); excepttype_i = 32'h0;
        dbus_dat_i = rdat; dbus_ack_i = 1'b0; stall = 6'h0; flush = 1'b0;
        exp_w = ld ? ref_load(op, addr, rdat) : wdata_i;
        for (int c = 0; c < lat; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("cyc_busy", 32'(dbus_cyc_o), 32'd1);
            check("stb_busy", 32'(dbus_stb_o), 32'd1);
            check("adr", dbus_adr_o, {addr[31:2], 2'b00});
            check("sel", 32'(dbus_sel_o), 32'(ref_sel(op, addr)));
            check("we", 32'(dbus_we_o), 32'(!ld));
            if (!ld) check("dat_o", dbus_dat_o, ref_store(op, st));
            stalls += int'(stallreq_o);
        end
        @(negedge clk);
        dbus_ack_i = 1'b1;
        stall = (hold > 0) ? 6'b01_1111 : 6'h0;
        #1;
        check("stall_cycles", 32'(stalls), 32'(lat));
        check("cyc_ack", 32'(dbus_cyc_o), 32'd0);
        check("stallreq_ack", 32'(stallreq_o), 32'd0);
        check("wdata_ack", wdata_o, exp_w);
        check("wreg_ack", 32'(wreg_o), 32'(ld));
        check("exc_ack", excepttype_o, 32'h0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            dbus_ack_i = 1'($urandom_range(0, 1));
            dbus_dat_i = $urandom;
            stall = (h < hold - 1) ? 6'b01_1111 : 6'h0;
            #1;
            check("wdata_hold", wdata_o, exp_w);
            check("cyc_hold", 32'(dbus_cyc_o), 32'd0);
            check("stallreq_hold", 32'(stallreq_o), 32'd0);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        logic [31:0] a;
        int n;
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

        // Reset with a live load presented: everything must read zero.
        drive_idle();
        rst = 1'b1;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; wdata_i = 32'h1234; wreg_i = 1'b1; wd_i = 5'd3;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cyc", 32'(dbus_cyc_o), 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wd", 32'(wd_o), 32'd0);
        check("rst_adr", dbus_adr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();

        // Directed cases from the test plan.
        run_mem(EXE_LW_OP,  32'h100, 32'h0, 32'hDEAD_BEEF, 3, 0);
        run_mem(EXE_LB_OP,  32'h103, 32'h0, 32'h80FF_FFFF, 1, 0);
        run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h80FF_FFFF, 2, 0);
        run_mem(EXE_SH_OP,  32'h202, 32'h1234_ABCD, 32'h0, 1, 0);
        run_mem(EXE_LH_OP,  32'h402, 32'h0, 32'h9876_0000, 2, 2);

        // Non-memory op passes straight through.
        @(negedge clk);
        aluop_i = 8'b0010_0101; wdata_i = 32'hCAFE_F00D; wreg_i = 1'b1; wd_i = 5'd9; #1;
        check("alu_wdata", wdata_o, 32'hCAFE_F00D);
        check("alu_wreg", 32'(wreg_o), 32'd1);
        check("alu_wd", 32'(wd_o), 32'd9);
        check("alu_cyc", 32'(dbus_cyc_o), 32'd0);

        // Misaligned load and store raise their exception bits without a bus cycle.
        @(negedge clk);
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h101; wreg_i = 1'b1; #1;
        check("mis_lw_cyc", 32'(dbus_cyc_o), 32'd0);
        check("mis_lw_exc", excepttype_o, 32'h10);
        check("mis_lw_stall", 32'(stallreq_o), 32'd0);
        check("mis_lw_wreg", 32'(wreg_o), 32'd0);
        @(negedge clk);
        aluop_i = EXE_SH_OP; mem_addr_i = 32'h203; wreg_i = 1'b0; #1;
        check("mis_sh_cyc", 32'(dbus_cyc_o), 32'd0);
        check("mis_sh_exc", excepttype_o, 32'h40);

        // Incoming exception suppresses the access and passes through.
        @(negedge clk);
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h104; wreg_i = 1'b1; excepttype_i = 32'h100; #1;
        check("exc_in_cyc", 32'(dbus_cyc_o), 32'd0);
        check("exc_in_pass", excepttype_o, 32'h100);
        check("exc_in_wreg", 32'(wreg_o), 32'd1);

        // Flush on the second BUSY cycle; a late ack must be ignored.
        @(negedge clk);
        drive_idle();
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h300; wreg_i = 1'b1; #1;
        check("fl_issue_cyc", 32'(dbus_cyc_o), 32'd1);
        @(negedge clk); #1;
        check("fl_busy1_cyc", 32'(dbus_cyc_o), 32'd1);
        @(negedge clk);
        flush = 1'b1; #1;
        check("fl_cyc", 32'(dbus_cyc_o), 32'd0);
        check("fl_stallreq", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        drive_idle();
        wdata_i = 32'h7777_1111; dbus_ack_i = 1'b1; dbus_dat_i = 32'hFFFF_FFFF; #1;
        check("late_ack_cyc", 32'(dbus_cyc_o), 32'd0);
        check("late_ack_stall", 32'(stallreq_o), 32'd0);
        check("late_ack_wdata", wdata_o, 32'h7777_1111);
        @(negedge clk);
        drive_idle();

        // Randomized aligned traffic.
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 7)];
            n = ref_size(op);
            a = ($urandom & 32'h0000_FFFC) | 32'(n * $urandom_range(0, (4 / n) - 1));
            run_mem(op, a, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 2));
        end

`ifdef MEM_LSU_TIMEOUT_EN
        begin
            int c;
            logic [31:0] exc_seen;
            c = 0;
            @(negedge clk);
            aluop_i = EXE_LW_OP; mem_addr_i = 32'h500; wreg_i = 1'b1; #1;
            while (dbus_cyc_o && c < 300) begin
                @(negedge clk); #1;
                c++;
            end
            exc_seen = excepttype_o;
            check("to_cycle", 32'(c), 32'd255);
            check("to_exc", exc_seen, 32'h20);
            check("to_wreg", 32'(wreg_o), 32'd0);
            @(negedge clk);
            drive_idle();
        end
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
